// File: rtl/seq_player_if.sv
// Round-controller bus: game-FSM handshake, sequence ROM port, buttons and LEDs.
// The slave modport is the seq_player side; master is the surrounding game logic.
interface seq_player_if;
    logic       start;
    logic [3:0] level;
    logic [3:0] address;
    logic [3:0] seq_in;
    logic [3:0] botoes;
    logic [3:0] leds;
    logic       busy;
    logic       round_ok;
    logic       round_fail;

    modport slave (
        input  start,
        input  level,
        input  seq_in,
        input  botoes,
        output address,
        output leds,
        output busy,
        output round_ok,
        output round_fail
    );

    modport master (
        output start,
        output level,
        output seq_in,
        output botoes,
        input  address,
        input  leds,
        input  busy,
        input  round_ok,
        input  round_fail
    );
endinterface

// File: rtl/seq_player.sv
// Game-round controller: replays steps 0..level of the sequence ROM on the
// LEDs, then checks the player's presses step by step and ends the round
// with a single-cycle ok or fail pulse.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | waiting for start, outputs quiet
// SHOW_ON      | current step's ROM word lit for SHOW_CYCLES
// SHOW_GAP     | LEDs dark for GAP_CYCLES, then next step or input phase
// WAIT_PRESS   | echo buttons, wait for a press matching ROM word (timeout)
// WAIT_RELEASE | echo buttons, wait for release (stuck-button timeout)
// ST_OK        | one-cycle round_ok pulse
// ST_FAIL      | one-cycle round_fail pulse
module seq_player #(
    parameter int SHOW_CYCLES    = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic          clk,
    input  logic          reset,
    seq_player_if.slave   bus
);

    localparam int MAX_A  = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int MAX_C  = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int TW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_ZERO    = '0;
    localparam logic [TW-1:0] T_ONE     = TW'(1);

    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] SHOW_ON      = 3'd1;
    localparam logic [2:0] SHOW_GAP     = 3'd2;
    localparam logic [2:0] WAIT_PRESS   = 3'd3;
    localparam logic [2:0] WAIT_RELEASE = 3'd4;
    localparam logic [2:0] ST_OK        = 3'd5;
    localparam logic [2:0] ST_FAIL      = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [3:0]    addr_q, addr_d;
    logic [3:0]    len_q, len_d;
    logic [TW-1:0] timer_q, timer_d;

    logic          last_step;
    logic          pressed;

    assign last_step = (addr_q == len_q);
    assign pressed   = (bus.botoes != 4'd0);

    // Next-state, address, timer and length computation for the round FSM.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    len_d   = bus.level;
                    addr_d  = 4'd0;
                    timer_d = T_ZERO;
                    state_d = SHOW_ON;
                end
            end
            SHOW_ON: begin
                if (timer_q == SHOW_LAST) begin
                    timer_d = T_ZERO;
                    state_d = SHOW_GAP;
                end else begin
                    timer_d = timer_q + T_ONE;
                end
            end
            SHOW_GAP: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = T_ZERO;
                    if (last_step) begin
                        addr_d  = 4'd0;
                        state_d = WAIT_PRESS;
                    end else begin
                        addr_d  = addr_q + 4'd1;
                        state_d = SHOW_ON;
                    end
                end else begin
                    timer_d = timer_q + T_ONE;
                end
            end
            WAIT_PRESS: begin
                if (!pressed) begin
                    if (timer_q == TO_LAST) begin
                        timer_d = T_ZERO;
                        state_d = ST_FAIL;
                    end else begin
                        timer_d = timer_q + T_ONE;
                    end
                end else if (bus.botoes == bus.seq_in) begin
                    timer_d = T_ZERO;
                    state_d = WAIT_RELEASE;
                end else begin
                    // multi-hot presses land here: they never equal a one-hot word
                    timer_d = T_ZERO;
                    state_d = ST_FAIL;
                end
            end
            WAIT_RELEASE: begin
                if (!pressed) begin
                    timer_d = T_ZERO;
                    if (last_step) begin
                        state_d = ST_OK;
                    end else begin
                        addr_d  = addr_q + 4'd1;
                        state_d = WAIT_PRESS;
                    end
                end else if (timer_q == TO_LAST) begin
                    timer_d = T_ZERO;
                    state_d = ST_FAIL;
                end else begin
                    timer_d = timer_q + T_ONE;
                end
            end
            ST_OK, ST_FAIL: begin
                timer_d = T_ZERO;
                state_d = IDLE;
            end
            default: begin
                timer_d = T_ZERO;
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset back to an idle, cleared round.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= 4'd0;
            len_q   <= 4'd0;
            timer_q <= T_ZERO;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            timer_q <= timer_d;
        end
    end

    // LED source follows the phase: ROM word while showing, button echo while playing.
    always_comb begin
        bus.leds = 4'd0;
        case (state_q)
            SHOW_ON:                  bus.leds = bus.seq_in;
            WAIT_PRESS, WAIT_RELEASE: bus.leds = bus.botoes;
            default:                  bus.leds = 4'd0;
        endcase
    end

    assign bus.address    = addr_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.round_ok   = (state_q == ST_OK);
    assign bus.round_fail = (state_q == ST_FAIL);

endmodule

// File: tb/tb_seq_player.sv
// Directed bench for seq_player: display timing, press checking, timeouts,
// mid-round reset, ignored start and a full 16-step round.
module tb_seq_player;

    localparam int SHOW = 4;
    localparam int GAP  = 2;
    localparam int TO   = 64;

    logic clk;
    logic reset;
    int   rom_mode;

    int   checks;
    int   failures;
    int   ok_cnt;
    int   fail_cnt;
    int   viol_cnt;

    seq_player_if bus ();

    seq_player #(
        .SHOW_CYCLES    (SHOW),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sequence ROM model: constant 0001, or one-hot rotating with the address.
    function automatic logic [3:0] rom_val(input int mode, input logic [3:0] a);
        logic [3:0] r;
        if (mode == 0) begin
            r = 4'b0001;
        end else begin
            case (a[1:0])
                2'd0: r = 4'b0001;
                2'd1: r = 4'b0010;
                2'd2: r = 4'b0100;
                default: r = 4'b1000;
            endcase
        end
        return r;
    endfunction

    always_comb bus.seq_in = rom_val(rom_mode, bus.address);

    // Pulse counters and exclusivity watch, sampled at the edge that ends each cycle.
    always @(posedge clk) begin
        if (bus.round_ok)   ok_cnt   <= ok_cnt + 1;
        if (bus.round_fail) fail_cnt <= fail_cnt + 1;
        if ((bus.round_ok && bus.round_fail) ||
            ((bus.round_ok || bus.round_fail) && !bus.busy))
            viol_cnt <= viol_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a round and check the whole display phase; optional stray start at cycle glitch.
    task automatic run_show(input logic [3:0] lv, input int glitch);
        int cyc;
        bus.level = lv;
        bus.start = 1'b1;
        check_eq("idle_busy", 32'(bus.busy), 32'd0);
        tick();
        bus.start = 1'b0;
        bus.level = 4'd0;
        cyc = 1;
        for (int s = 0; s <= int'(lv); s++) begin
            for (int c = 0; c < SHOW; c++) begin
                bus.start = (cyc == glitch);
                bus.level = (cyc == glitch) ? 4'd15 : 4'd0;
                check_eq("show_addr", 32'(bus.address), 32'(s));
                check_eq("show_leds", 32'(bus.leds), 32'(rom_val(rom_mode, 4'(s))));
                check_eq("show_busy", 32'(bus.busy), 32'd1);
                tick();
                cyc++;
            end
            for (int c = 0; c < GAP; c++) begin
                bus.start = (cyc == glitch);
                bus.level = (cyc == glitch) ? 4'd15 : 4'd0;
                check_eq("gap_leds", 32'(bus.leds), 32'd0);
                check_eq("gap_addr", 32'(bus.address), 32'(s));
                tick();
                cyc++;
            end
        end
        bus.start = 1'b0;
        bus.level = 4'd0;
        check_eq("wait_addr0", 32'(bus.address), 32'd0);
        check_eq("wait_busy", 32'(bus.busy), 32'd1);
    endtask

    // One press-then-release pair: press this cycle, release the next.
    task automatic press_release(input logic [3:0] v);
        bus.botoes = v;
        tick();
        check_eq("echo_leds", 32'(bus.leds), 32'(v));
        check_eq("rel_nofail", 32'(bus.round_fail), 32'd0);
        bus.botoes = 4'd0;
        tick();
    endtask

    initial begin
        int ok0;
        int f0;
        checks    = 0;
        failures  = 0;
        ok_cnt    = 0;
        fail_cnt  = 0;
        viol_cnt  = 0;
        rom_mode  = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.level = 4'd0;
        bus.botoes = 4'd0;
        tick();
        tick();
        check_eq("rst_addr", 32'(bus.address), 32'd0);
        check_eq("rst_leds", 32'(bus.leds), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_ok",   32'(bus.round_ok), 32'd0);
        check_eq("rst_fail", 32'(bus.round_fail), 32'd0);
        reset = 1'b0;
        tick();

        // level=0: display cycles 1-6, press at 9, release at 11, ok at 12
        ok0 = ok_cnt;
        run_show(4'd0, -1);
        tick();
        tick();
        bus.botoes = 4'b0001;
        tick();
        check_eq("t1_echo", 32'(bus.leds), 32'd1);
        tick();
        bus.botoes = 4'b0000;
        tick();
        check_eq("t1_ok", 32'(bus.round_ok), 32'd1);
        check_eq("t1_ok_busy", 32'(bus.busy), 32'd1);
        check_eq("t1_ok_leds", 32'(bus.leds), 32'd0);
        tick();
        check_eq("t1_ok_end", 32'(bus.round_ok), 32'd0);
        check_eq("t1_idle", 32'(bus.busy), 32'd0);
        check_eq("t1_okcnt", 32'(ok_cnt - ok0), 32'd1);

        // level=2 with a stray start mid-display: timing and addresses unchanged
        ok0 = ok_cnt;
        f0  = fail_cnt;
        run_show(4'd2, 3);
        for (int i = 0; i < 3; i++) press_release(4'b0001);
        check_eq("t2_ok", 32'(bus.round_ok), 32'd1);
        tick();
        check_eq("t2_idle", 32'(bus.busy), 32'd0);
        check_eq("t2_okcnt", 32'(ok_cnt - ok0), 32'd1);
        check_eq("t2_failcnt", 32'(fail_cnt - f0), 32'd0);

        // level=3, wrong second press
        f0 = fail_cnt;
        run_show(4'd3, -1);
        press_release(4'b0001);
        check_eq("t3_addr1", 32'(bus.address), 32'd1);
        bus.botoes = 4'b0010;
        tick();
        check_eq("t3_fail", 32'(bus.round_fail), 32'd1);
        check_eq("t3_fail_ok", 32'(bus.round_ok), 32'd0);
        bus.botoes = 4'd0;
        tick();
        check_eq("t3_fail_end", 32'(bus.round_fail), 32'd0);
        check_eq("t3_idle", 32'(bus.busy), 32'd0);
        check_eq("t3_failcnt", 32'(fail_cnt - f0), 32'd1);

        // level=3, multi-hot first press
        run_show(4'd3, -1);
        bus.botoes = 4'b0011;
        tick();
        check_eq("t4_multihot", 32'(bus.round_fail), 32'd1);
        bus.botoes = 4'd0;
        tick();
        check_eq("t4_idle", 32'(bus.busy), 32'd0);

        // press timeout: fail exactly TO cycles after entering WAIT_PRESS
        run_show(4'd0, -1);
        for (int i = 0; i < TO; i++) begin
            check_eq("to_early", 32'(bus.round_fail), 32'd0);
            tick();
        end
        check_eq("to_fail", 32'(bus.round_fail), 32'd1);
        tick();
        check_eq("to_idle", 32'(bus.busy), 32'd0);

        // stuck button held 70 cycles: fail TO cycles after entering WAIT_RELEASE
        ok0 = ok_cnt;
        run_show(4'd0, -1);
        bus.botoes = 4'b0001;
        tick();
        for (int i = 0; i < TO; i++) begin
            check_eq("stuck_early", 32'(bus.round_fail), 32'd0);
            tick();
        end
        check_eq("stuck_fail", 32'(bus.round_fail), 32'd1);
        for (int i = 0; i < 70 - TO - 1; i++) tick();
        bus.botoes = 4'd0;
        tick();
        check_eq("stuck_idle", 32'(bus.busy), 32'd0);
        check_eq("stuck_nook", 32'(ok_cnt - ok0), 32'd0);

        // reset during the second SHOW_ON of level=5
        ok0 = ok_cnt;
        f0  = fail_cnt;
        bus.level = 4'd5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        check_eq("mr_addr1", 32'(bus.address), 32'd1);
        check_eq("mr_lit", 32'(bus.leds), 32'd1);
        reset = 1'b1;
        tick();
        check_eq("mr_addr", 32'(bus.address), 32'd0);
        check_eq("mr_leds", 32'(bus.leds), 32'd0);
        check_eq("mr_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        tick();
        tick();
        check_eq("mr_stay_idle", 32'(bus.busy), 32'd0);
        check_eq("mr_nopulse", 32'((ok_cnt - ok0) + (fail_cnt - f0)), 32'd0);

        // level=15 with address-dependent one-hot ROM
        rom_mode = 1;
        ok0 = ok_cnt;
        run_show(4'd15, -1);
        for (int i = 0; i < 16; i++) begin
            check_eq("l15_addr", 32'(bus.address), 32'(i));
            press_release(rom_val(1, 4'(i)));
        end
        check_eq("l15_ok", 32'(bus.round_ok), 32'd1);
        tick();
        check_eq("l15_okcnt", 32'(ok_cnt - ok0), 32'd1);
        check_eq("l15_idle", 32'(bus.busy), 32'd0);

        check_eq("pulse_excl", 32'(viol_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

endmodule
